xlr8_prbs_check: RTL and testbench



---
 rtl/xlr8_prbs_check.sv | 150 +++++++++++++++
 tb/tb_xlr8_prbs_check.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/xlr8_prbs_check.sv
// PRBS checker Xcelerator Block: self-synchronises to the XLR8 8-bit LFSR byte stream
// written over the data-memory bus, tracks lock/loss of lock and counts bit-stream errors.
module xlr8_prbs_check #(
  parameter logic [7:0] CTRL_ADDR  = 8'h00,
  parameter logic [7:0] STAT_ADDR  = 8'h00,
  parameter logic [7:0] DATA_ADDR  = 8'h00,
  parameter logic [7:0] ERRC_ADDR  = 8'h00,
  parameter int         LOCK_COUNT = 3,
  parameter int         LOSS_COUNT = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clken,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  output logic       io_out_en,
  input  logic [7:0] ramadr,
  input  logic       ramre,
  input  logic       ramwe,
  input  logic       dm_sel
);

  typedef enum logic [1:0] {IDLE = 2'b00, HUNT = 2'b01, VERIFY = 2'b10, LOCKED = 2'b11} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  function automatic logic [7:0] step(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  state_t     state, state_nxt;
  logic       en, en_nxt;
  logic       lost, lost_nxt;
  logic [7:0] expected, exp_nxt;
  logic [7:0] errc, errc_nxt;
  logic [3:0] match_cnt, match_nxt;
  logic [3:0] bad_run, bad_nxt;

  logic sel_ctrl, sel_stat, sel_data, sel_errc;
  logic ctrl_wr, byte_ev;
  logic [3:0] match_inc, bad_inc;
  logic [7:0] step_b, step_e;

  assign sel_ctrl = dm_sel && (ramadr == CTRL_ADDR);
  assign sel_stat = dm_sel && (ramadr == STAT_ADDR);
  assign sel_data = dm_sel && (ramadr == DATA_ADDR);
  assign sel_errc = dm_sel && (ramadr == ERRC_ADDR);

  assign ctrl_wr   = clken && ramwe && sel_ctrl;
  assign byte_ev   = clken && ramwe && sel_data && en;
  assign match_inc = match_cnt + 4'd1;
  assign bad_inc   = bad_run + 4'd1;
  assign step_b    = step(dbus_in);
  assign step_e    = step(expected);

  always_comb begin
    state_nxt = state;
    en_nxt    = en;
    lost_nxt  = lost;
    exp_nxt   = expected;
    errc_nxt  = errc;
    match_nxt = match_cnt;
    bad_nxt   = bad_run;
    if (ctrl_wr) begin
      en_nxt = dbus_in[0];
      if (dbus_in[1]) begin
        errc_nxt  = 8'h00;
        lost_nxt  = 1'b0;
        match_nxt = 4'd0;
        bad_nxt   = 4'd0;
        state_nxt = dbus_in[0] ? HUNT : IDLE;
      end else if (!dbus_in[0]) begin
        state_nxt = IDLE;
      end else if (!en) begin
        state_nxt = HUNT;
      end
    end else if (byte_ev) begin
      case (state)
        HUNT: begin
          // 0x00 is the LFSR lock-up value, never a usable seed
          if (dbus_in != 8'h00) begin
            exp_nxt   = step_b;
            match_nxt = 4'd0;
            state_nxt = VERIFY;
          end
        end
        VERIFY: begin
          if (dbus_in == expected) begin
            match_nxt = match_inc;
            exp_nxt   = step_b;
            if (match_inc == LOCK_N) begin
              state_nxt = LOCKED;
              bad_nxt   = 4'd0;
            end
          end else if (dbus_in != 8'h00) begin
            exp_nxt   = step_b;
            match_nxt = 4'd0;
          end else begin
            state_nxt = HUNT;
          end
        end
        LOCKED: begin
          // free-running: isolated errors never resync the local LFSR
          exp_nxt = step_e;
          if (dbus_in == expected) begin
            bad_nxt = 4'd0;
          end else begin
            if (errc != 8'hFF) errc_nxt = errc + 8'd1;
            bad_nxt = bad_inc;
            if (bad_inc == LOSS_N) begin
              state_nxt = HUNT;
              lost_nxt  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      en        <= 1'b0;
      lost      <= 1'b0;
      expected  <= 8'h00;
      errc      <= 8'h00;
      match_cnt <= 4'd0;
      bad_run   <= 4'd0;
    end else if (clken) begin
      state     <= state_nxt;
      en        <= en_nxt;
      lost      <= lost_nxt;
      expected  <= exp_nxt;
      errc      <= errc_nxt;
      match_cnt <= match_nxt;
      bad_run   <= bad_nxt;
    end
  end

  logic [7:0] ctrl_rd, stat_rd;
  assign ctrl_rd = {7'd0, en};
  assign stat_rd = {3'd0, errc == 8'hFF, state, lost, state == LOCKED};

  assign dbus_out = ({8{sel_ctrl}} & ctrl_rd) | ({8{sel_stat}} & stat_rd) |
                    ({8{sel_data}} & expected) | ({8{sel_errc}} & errc);
  assign io_out_en = ramre && (sel_ctrl || sel_stat || sel_data || sel_errc);

endmodule

// File: tb/tb_xlr8_prbs_check.sv
// Bench for xlr8_prbs_check: directed scenarios plus randomized traffic, all
// compared against a behavioural model of the checker kept here.
module tb_xlr8_prbs_check;
  localparam logic [7:0] A_CTRL = 8'h40;
  localparam logic [7:0] A_STAT = 8'h41;
  localparam logic [7:0] A_DATA = 8'h42;
  localparam logic [7:0] A_ERRC = 8'h43;
  localparam int LOCK_C = 3;
  localparam int LOSS_C = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clken = 1'b1;
  logic [7:0] dbus_in = 8'h00;
  logic [7:0] dbus_out;
  logic       io_out_en;
  logic [7:0] ramadr = 8'h00;
  logic       ramre = 1'b0;
  logic       ramwe = 1'b0;
  logic       dm_sel = 1'b0;

  xlr8_prbs_check #(
    .CTRL_ADDR(A_CTRL), .STAT_ADDR(A_STAT), .DATA_ADDR(A_DATA), .ERRC_ADDR(A_ERRC),
    .LOCK_COUNT(LOCK_C), .LOSS_COUNT(LOSS_C)
  ) dut (
    .clk(clk), .rstn(rstn), .clken(clken), .dbus_in(dbus_in), .dbus_out(dbus_out),
    .io_out_en(io_out_en), .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe), .dm_sel(dm_sel)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Reference model: states 0 idle, 1 hunt, 2 verify, 3 locked
  int m_en, m_st, m_exp, m_match, m_bad, m_lost, m_errc;

  function automatic int m_step(input int x);
    return ((x * 2) & 255) | (((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1);
  endfunction

  function automatic logic [7:0] m_stat();
    return 8'(((m_errc == 255) ? 16 : 0) + m_st * 4 + m_lost * 2 + ((m_st == 3) ? 1 : 0));
  endfunction

  task automatic m_reset();
    m_en = 0; m_st = 0; m_exp = 0; m_match = 0; m_bad = 0; m_lost = 0; m_errc = 0;
  endtask

  task automatic m_apply(input logic [7:0] a, input int d);
    if (a == A_CTRL) begin
      int new_en = d & 1;
      if (d & 2) begin
        m_errc = 0; m_lost = 0; m_match = 0; m_bad = 0;
        m_st = new_en ? 1 : 0;
      end else if (!new_en) m_st = 0;
      else if (!m_en) m_st = 1;
      m_en = new_en;
    end else if (a == A_DATA && m_en == 1) begin
      if (m_st == 1) begin
        if (d != 0) begin m_exp = m_step(d); m_match = 0; m_st = 2; end
      end else if (m_st == 2) begin
        if (d == m_exp) begin
          m_match++; m_exp = m_step(d);
          if (m_match == LOCK_C) begin m_st = 3; m_bad = 0; end
        end else if (d != 0) begin m_exp = m_step(d); m_match = 0; end
        else m_st = 1;
      end else if (m_st == 3) begin
        if (d == m_exp) m_bad = 0;
        else begin
          if (m_errc < 255) m_errc++;
          m_bad++;
          if (m_bad == LOSS_C) begin m_st = 1; m_lost = 1; end
        end
        m_exp = m_step(m_exp);
      end
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic ce = 1'b1);
    dm_sel = 1'b1; ramwe = 1'b1; ramadr = a; dbus_in = d; clken = ce;
    @(posedge clk);
    if (ce) m_apply(a, int'(d));
    #1;
    ramwe = 1'b0; dm_sel = 1'b0; clken = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    dm_sel = 1'b1; ramre = 1'b1; ramadr = a;
    #1;
    chk(tag, dbus_out, exp);
    ramre = 1'b0; dm_sel = 1'b0;
  endtask

  task automatic check_all(input string tag);
    rd({tag, ".ctrl"}, A_CTRL, 8'(m_en));
    rd({tag, ".stat"}, A_STAT, m_stat());
    rd({tag, ".data"}, A_DATA, 8'(m_exp));
    rd({tag, ".errc"}, A_ERRC, 8'(m_errc));
  endtask

  task automatic do_reset(input logic ce);
    clken = ce; rstn = 1'b0;
    @(posedge clk);
    m_reset();
    #1;
    rstn = 1'b1; clken = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // reset values and bus decode
    rd("rst.ctrl", A_CTRL, 8'h00);
    rd("rst.stat", A_STAT, 8'h00);
    rd("rst.data", A_DATA, 8'h00);
    rd("rst.errc", A_ERRC, 8'h00);
    dm_sel = 1'b1; ramadr = A_STAT; ramre = 1'b1; #1;
    chk("oe.read", 8'(io_out_en), 8'h01);
    ramre = 1'b0; #1;
    chk("oe.noread", 8'(io_out_en), 8'h00);
    ramadr = 8'h44; ramre = 1'b1; #1;
    chk("oe.unmapped", 8'(io_out_en), 8'h00);
    chk("dout.unmapped", dbus_out, 8'h00);
    ramadr = A_STAT; dm_sel = 1'b0; #1;
    chk("oe.nodmsel", 8'(io_out_en), 8'h00);
    ramre = 1'b0;

    // acquire lock from 0x01
    wr(A_CTRL, 8'h01);
    rd("en.stat", A_STAT, 8'h04);
    wr(A_DATA, 8'h01);
    rd("seed.stat", A_STAT, 8'h08);
    rd("seed.data", A_DATA, 8'h02);
    wr(A_DATA, 8'h02); wr(A_DATA, 8'h04); wr(A_DATA, 8'h08);
    rd("lock.stat", A_STAT, 8'h0D);
    rd("lock.data", A_DATA, 8'h11);
    rd("lock.errc", A_ERRC, 8'h00);

    // isolated error while locked
    wr(A_DATA, 8'h11); wr(A_DATA, 8'hFF); wr(A_DATA, 8'h47);
    rd("iso.errc", A_ERRC, 8'h01);
    rd("iso.stat", A_STAT, 8'h0D);
    rd("iso.data", A_DATA, 8'h8E);

    // four consecutive errors lose lock
    for (int i = 0; i < 4; i++) wr(A_DATA, 8'(~m_exp));
    rd("loss.errc", A_ERRC, 8'h05);
    rd("loss.stat", A_STAT, 8'h06);
    wr(A_CTRL, 8'h03);
    rd("clr.errc", A_ERRC, 8'h00);
    rd("clr.stat", A_STAT, 8'h04);
    rd("clr.ctrl", A_CTRL, 8'h01);

    // 0x00 never seeds; VERIFY mismatch reseeds without counting
    wr(A_DATA, 8'h00); wr(A_DATA, 8'h00);
    rd("hunt0.stat", A_STAT, 8'h04);
    wr(A_DATA, 8'h05);
    wr(A_DATA, 8'h33);
    rd("reseed.stat", A_STAT, 8'h08);
    rd("reseed.data", A_DATA, 8'(m_step(8'h33)));
    rd("reseed.errc", A_ERRC, 8'h00);

    // clken=0 suppresses a byte event
    wr(A_DATA, 8'(m_exp), 1'b0);
    check_all("noclken");

    // reset mid-VERIFY, with clken low
    do_reset(1'b0);
    check_all("midrst");
    rd("midrst.stat", A_STAT, 8'h00);

    // saturate ERRC: three errors then a match keeps lock
    wr(A_CTRL, 8'h01);
    wr(A_DATA, 8'h01); wr(A_DATA, 8'h02); wr(A_DATA, 8'h04); wr(A_DATA, 8'h08);
    for (int g = 0; g < 87; g++) begin
      for (int e = 0; e < 3; e++) wr(A_DATA, 8'(m_exp ^ 1));
      wr(A_DATA, 8'(m_exp));
    end
    rd("sat.errc", A_ERRC, 8'hFF);
    rd("sat.stat", A_STAT, 8'h1D);
    wr(A_CTRL, 8'h03);
    rd("satclr.stat", A_STAT, 8'h04);

    // randomized traffic against the model
    for (int it = 0; it < 3000; it++) begin
      int r = $urandom_range(0, 99);
      if (r < 3) begin
        logic [7:0] c;
        c = 8'(($urandom_range(0, 9) != 0 ? 1 : 0) + ($urandom_range(0, 3) == 0 ? 2 : 0));
        wr(A_CTRL, c);
      end else if (r < 8) begin
        wr(A_DATA, 8'($urandom), 1'b0);
      end else if (r < 10) begin
        wr(A_DATA, 8'h00);
      end else if (r < 80) begin
        wr(A_DATA, 8'(m_exp));
      end else begin
        wr(A_DATA, 8'($urandom));
      end
      if (it % 4 == 0) check_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
